alu_fetch_queue: RTL

//   Instruction fetch/issue front end for the 4-stage ALU pipeline. Holds a loadable

---
 rtl/alu_fetch_queue.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/alu_fetch_queue.sv
// Instruction fetch/issue front end: loadable imem, program counter and a prefetch FIFO
// with valid/ready issue. Define ALU_FETCH_LOOP_EN to make the fetch loop over the program until stop.
module alu_fetch_queue #(
  parameter int WIDTH      = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int IW = 2*WIDTH+2,
  localparam int AW = $clog2(IMEM_DEPTH),
  localparam int FW = $clog2(FIFO_DEPTH),
  localparam int CW = FW+1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load_en,
  input  logic [AW-1:0] i_load_addr,
  input  logic [IW-1:0] i_load_instr,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic [AW:0]   i_prog_len,
  output logic          o_issue_valid,
  output logic [IW-1:0] o_issue_instr,
  input  logic          i_issue_ready,
  output logic          o_busy,
  output logic          o_done,
  output logic [CW-1:0] o_fifo_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_pc;
  logic [AW:0]   w_pc_nxt;
  logic [AW:0]   r_len;
  logic [AW:0]   w_len_nxt;
  logic          r_done;
  logic          w_done_nxt;
  logic          r_busy;

  logic [IW-1:0] r_mem  [IMEM_DEPTH];
  logic [IW-1:0] r_fifo [FIFO_DEPTH];
  logic [FW-1:0] r_wr_ptr;
  logic [FW-1:0] r_rd_ptr;
  logic [FW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_valid;
  logic [IW-1:0] r_head;
  logic [IW-1:0] w_head_nxt;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_last;
  logic [IW-1:0] w_fetch_word;

  assign w_full       = (r_count == CW'(FIFO_DEPTH));
  assign w_pop        = r_valid & i_issue_ready;
  assign w_last       = (r_pc == (r_len - (AW+1)'(1)));
  assign w_fetch_word = r_mem[r_pc[AW-1:0]];

  // Next-state, pc and push decision; stop takes priority over a push in FETCH.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_len_nxt   = r_len;
    w_done_nxt  = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_prog_len != (AW+1)'(0)) begin
            w_state_nxt = S_FETCH;
            w_pc_nxt    = (AW+1)'(0);
            w_len_nxt   = i_prog_len;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (i_stop) begin
          w_state_nxt = S_DRAIN;
        end else if (!w_full) begin
          w_push = 1'b1;
          if (w_last) begin
`ifdef ALU_FETCH_LOOP_EN
            w_pc_nxt    = (AW+1)'(0);
`else
            w_pc_nxt    = r_pc + (AW+1)'(1);
            w_state_nxt = S_DRAIN;
`endif
          end else begin
            w_pc_nxt = r_pc + (AW+1)'(1);
          end
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      S_DRAIN: begin
        if (r_count == CW'(0)) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Occupancy, read pointer and the registered head word for the next cycle.
  always_comb begin
    w_count_nxt  = r_count;
    w_rd_ptr_nxt = r_rd_ptr;
    w_head_nxt   = r_head;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + FW'(1);
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
    // The new head is the incoming word only when nothing older survives this edge.
    if (w_count_nxt == CW'(0)) begin
      w_head_nxt = IW'(0);
    end else if ((r_count == CW'(0)) || ((r_count == CW'(1)) && w_pop)) begin
      w_head_nxt = w_fetch_word;
    end else begin
      w_head_nxt = r_fifo[w_rd_ptr_nxt];
    end
  end

  // Control and FIFO bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pc     <= (AW+1)'(0);
      r_len    <= (AW+1)'(0);
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_wr_ptr <= FW'(0);
      r_rd_ptr <= FW'(0);
      r_count  <= CW'(0);
      r_valid  <= 1'b0;
      r_head   <= IW'(0);
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_len    <= w_len_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_wr_ptr <= w_push ? (r_wr_ptr + FW'(1)) : r_wr_ptr;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != CW'(0));
      r_head   <= w_head_nxt;
    end
  end

  // FIFO storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_fetch_word;
    end
  end

  // Instruction memory is writable only while idle and keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (i_load_en && (r_state == S_IDLE)) begin
      r_mem[i_load_addr] <= i_load_instr;
    end
  end

  assign o_issue_valid = r_valid;
  assign o_issue_instr = r_head;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_fifo_count  = r_count;

endmodule
